// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Address/instruction widths, the bubble word and the queued {PC, instr} payload.
package instr_fetch_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [ADDR_W-1:0]  RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  PC_STEP       = 32'd4;

    // Memory request tracker: idle, waiting on a live response, or waiting on a stale one.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DROP = 2'd2
    } req_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Sequential fetch address; wraps silently at the top of the address space.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// In-order queue of fetched {PC, instr} entries between instruction memory and IF/ID.
// Push, pop and clear act on the same edge; clear wins over everything else.
module instr_fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         clear,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t      mem_q [DEPTH];
    fetch_entry_t      mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Pointers rely on DEPTH being a power of two to wrap for free.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// IF stage: owns the fetch PC, runs the single-outstanding imem req/ack handshake,
// queues responses and drives the IF/ID register under decode stall and redirect.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = RESET_PC_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter int unsigned        QDEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hazard,
    input  logic               pcWriteEnable,
    input  logic [ADDR_W-1:0]  pcWriteData,
    output logic               imemReq,
    output logic [ADDR_W-1:0]  imemAddr,
    input  logic               imemAck,
    input  logic [INSTR_W-1:0] imemData,
    output logic [ADDR_W-1:0]  PC,
    output logic [INSTR_W-1:0] instr,
    output logic               fetchValid,
    output logic               flush
);

    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    req_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               fetch_valid_q, fetch_valid_d;
    logic               flush_q, flush_d;

    logic               issue_c;
    logic               fifo_push, fifo_pop, fifo_clear;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    fetch_entry_t       fifo_head;
    fetch_entry_t       push_entry;

    // Space is judged on queued words only; the single outstanding slot is tracked by state.
    assign issue_c = reset && (state_q == ST_IDLE) && (fifo_count < CNT_W'(QDEPTH))
                     && !pcWriteEnable;

    assign fifo_push  = imemAck && (state_q == ST_BUSY) && !pcWriteEnable;
    assign fifo_pop   = !pcWriteEnable && !hazard && !fifo_empty;
    assign fifo_clear = pcWriteEnable;
    assign push_entry = '{pc: req_pc_q, instr: imemData};

    instr_fetch_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .clear     (fifo_clear),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        fetch_valid_d = fetch_valid_q;
        flush_d       = 1'b0;

        // A redirect while waiting turns the pending response into one to throw away.
        case (state_q)
            ST_IDLE: begin
                if (issue_c) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (imemAck)            state_d = ST_IDLE;
                else if (pcWriteEnable) state_d = ST_DROP;
            end
            ST_DROP: begin
                if (imemAck) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue_c) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = next_pc(fetch_pc_q);
        end

        // Redirect beats the stall: the IF/ID register is bubbled even under hazard.
        if (pcWriteEnable) begin
            fetch_pc_d    = pcWriteData;
            instr_d       = NOP_INSTR;
            fetch_valid_d = 1'b0;
            flush_d       = 1'b1;
        end else if (!hazard) begin
            if (!fifo_empty) begin
                pc_d          = fifo_head.pc;
                instr_d       = fifo_head.instr;
                fetch_valid_d = 1'b1;
            end else begin
                instr_d       = NOP_INSTR;
                fetch_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= '0;
            pc_q          <= '0;
            instr_q       <= NOP_INSTR;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
        end
    end

    // A response only ever lands in a queue with room, since issue waits for space.
    assert property (@(posedge clk) disable iff (!reset) fifo_push |-> !fifo_full);

    assign imemReq    = issue_c;
    assign imemAddr   = fetch_pc_q;
    assign PC         = pc_q;
    assign instr      = instr_q;
    assign fetchValid = fetch_valid_q;
    assign flush      = flush_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory responder with variable ack latency,
// scoreboard of issued fetches, and a behavioural IF/ID model checked every cycle.
module tb_instr_fetch;

    localparam int          QDEPTH   = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, hazard, pcWriteEnable, imemAck;
    logic        imemReq, fetchValid, flush;
    logic [31:0] pcWriteData, imemAddr, imemData, PC, instr;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP),
        .QDEPTH    (QDEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .hazard        (hazard),
        .pcWriteEnable (pcWriteEnable),
        .pcWriteData   (pcWriteData),
        .imemReq       (imemReq),
        .imemAddr      (imemAddr),
        .imemAck       (imemAck),
        .imemData      (imemData),
        .PC            (PC),
        .instr         (instr),
        .fetchValid    (fetchValid),
        .flush         (flush)
    );

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [63:0] sb [$];
    int          n_rdy;
    bit          pend, pend_live;
    int          pend_cnt;
    logic [31:0] pend_addr;
    int          lat;
    bit          junk_ack;
    bit          last_req;
    logic [31:0] exp_next, exp_pc, exp_instr;
    bit          exp_valid, exp_flush;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check request side, advance model, check IF/ID after the edge.
    task automatic cycle(input bit rst, input bit haz, input bit redir, input logic [31:0] tgt);
        bit          ack_now, req, exp_req;
        logic [31:0] addr;
        logic [63:0] e;
        ack_now       = rst && pend && (pend_cnt == 0);
        reset         = rst;
        hazard        = haz;
        pcWriteEnable = redir;
        pcWriteData   = tgt;
        imemAck       = ack_now || junk_ack;
        imemData      = ack_now ? mem_word(pend_addr) : 32'hDEAD_BEEF;
        #1;
        req      = imemReq;
        addr     = imemAddr;
        last_req = req;
        exp_req  = rst && !pend && (n_rdy < QDEPTH) && !redir;
        check("imemReq", 32'(req), 32'(exp_req));
        if (req && exp_req) check("imemAddr", addr, exp_next);

        if (!rst) begin
            sb.delete();
            n_rdy     = 0;
            pend      = 1'b0;
            pend_live = 1'b0;
            exp_next  = RST_PC;
            exp_pc    = 32'h0;
            exp_instr = NOP;
            exp_valid = 1'b0;
            exp_flush = 1'b0;
        end else begin
            if (redir) begin
                sb.delete();
                n_rdy     = 0;
                pend_live = 1'b0;
                exp_next  = tgt;
                exp_flush = 1'b1;
                exp_valid = 1'b0;
                exp_instr = NOP;
            end else begin
                exp_flush = 1'b0;
                if (!haz) begin
                    if (n_rdy > 0) begin
                        e         = sb.pop_front();
                        exp_pc    = e[63:32];
                        exp_instr = e[31:0];
                        exp_valid = 1'b1;
                        n_rdy--;
                    end else begin
                        exp_instr = NOP;
                        exp_valid = 1'b0;
                    end
                end
                if (ack_now && pend_live) n_rdy++;
            end
            if (ack_now) begin
                pend      = 1'b0;
                pend_live = 1'b0;
            end else if (pend) begin
                pend_cnt--;
            end
            if (req) begin
                sb.push_back({addr, mem_word(addr)});
                exp_next  = addr + 32'd4;
                pend      = 1'b1;
                pend_live = 1'b1;
                pend_addr = addr;
                pend_cnt  = lat - 1;
            end
        end

        @(posedge clk);
        #1;
        junk_ack = 1'b0;
        check("PC", PC, exp_pc);
        check("instr", instr, exp_instr);
        check("fetchValid", 32'(fetchValid), 32'(exp_valid));
        check("flush", 32'(flush), 32'(exp_flush));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit          found;
        bit          h, r;
        logic [31:0] t;
        reset = 1'b0; hazard = 1'b0; pcWriteEnable = 1'b0; pcWriteData = '0;
        imemAck = 1'b0; imemData = '0;
        sb.delete(); n_rdy = 0; pend = 1'b0; pend_live = 1'b0; pend_cnt = 0;
        pend_addr = '0; lat = 1; junk_ack = 1'b0; last_req = 1'b0;
        exp_next = RST_PC; exp_pc = '0; exp_instr = NOP; exp_valid = 1'b0; exp_flush = 1'b0;

        // Reset held three cycles
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("rst_instr", instr, NOP);
        check("rst_valid", 32'(fetchValid), 32'h0);

        // Straight-line fetch with 1-cycle ack until PC 8 reaches IF/ID
        lat = 1;
        for (int i = 0; i < 40 && !(exp_valid && exp_pc == 32'h8); i++)
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("tmo_reach_pc8", 32'(exp_valid && exp_pc == 32'h8), 32'h1);

        // Hazard for 4 cycles: IF/ID frozen, queue fills and requests stop
        repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("haz_pc_hold", PC, 32'h8);
        check("haz_req_stall", 32'(last_req), 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("rel_pc12", PC, 32'hC);
        check("rel_valid12", 32'(fetchValid), 32'h1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("rel_pc16", PC, 32'h10);
        check("rel_valid16", 32'(fetchValid), 32'h1);

        // Rewind, then redirect to 0x100 while the 0x10 request is outstanding
        cycle(1'b1, 1'b0, 1'b1, 32'h8);
        lat = 3;
        for (int i = 0; i < 40 && !(pend && pend_addr == 32'h10); i++)
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("tmo_req_0x10", 32'(pend && pend_addr == 32'h10), 32'h1);
        cycle(1'b1, 1'b0, 1'b1, 32'h100);
        check("redir_flush", 32'(flush), 32'h1);
        check("redir_bubble", 32'(fetchValid), 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("redir_flush_1cyc", 32'(flush), 32'h0);
        for (int i = 0; i < 40 && !exp_valid; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("redir_first_pc", PC, 32'h100);
        check("redir_first_instr", instr, mem_word(32'h100));

        // Redirect in the same cycle as an ack, with hazard asserted
        lat = 2;
        for (int i = 0; i < 40 && !exp_valid; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 40 && !(pend && pend_cnt == 0); i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("tmo_ack_align", 32'(pend && pend_cnt == 0 && exp_valid), 32'h1);
        cycle(1'b1, 1'b1, 1'b1, 32'h200);
        check("redack_flush", 32'(flush), 32'h1);
        check("redack_bubble", 32'(fetchValid), 32'h0);
        check("redack_nop", instr, NOP);
        repeat (8) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Address wrap at the top of memory
        lat = 1;
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            found = pend && (pend_addr != 32'hFFFF_FFFC);
        end
        check("tmo_wrap", 32'(found), 32'h1);
        check("wrap_req_addr", pend_addr, 32'h0);
        repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Reset while a request is outstanding, then a stray ack right after release
        lat = 3;
        for (int i = 0; i < 40 && !pend; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("rstmid_pc", PC, 32'h0);
        check("rstmid_instr", instr, NOP);
        check("rstmid_valid", 32'(fetchValid), 32'h0);
        junk_ack = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 40 && !exp_valid; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("late_ack_pc", PC, 32'h0);
        check("late_ack_instr", instr, mem_word(32'h0));

        // Random mix of stalls, redirects and ack latencies
        for (int i = 0; i < 300; i++) begin
            if (!pend) lat = int'($urandom_range(1, 3));
            h = ($urandom_range(0, 9) < 3);
            r = ($urandom_range(0, 19) == 0);
            t = $urandom();
            cycle(1'b1, h, r, t);
        end
        repeat (12) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
